banked_reg_file: RTL

- Parametrised register file for the CSE141L datapath: main bank of 2**A registers, W bits each, with two combinational read ports and one clocked write port.
- Adds a dedicated jump register with its own write enable.
- Adds optional write-to-read bypass.
- Adds a shadow bank with a multi-cycle save/restore engine, for context snapshot around interrupts or subroutine calls.
- Sits between the decoder/ALU writeback and the ALU operand muxes; the sequencer uses Busy to stall issue.

---
 rtl/banked_reg_file.sv | 114 +++++++++++
 1 files changed

// File: rtl/banked_reg_file.sv
// Register file: 2**A x W main bank, two combinational read ports, jump register, and a shadow bank
// with a save/restore engine that copies one entry per cycle; Busy blocks main writes while copying.
module banked_reg_file #(
  parameter int W      = 8,
  parameter int A      = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         WriteEn,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  input  logic         SetInst,
  input  logic         JumpWe,
  input  logic         SaveReq,
  input  logic         RestoreReq,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  output logic [W-1:0] JumpReg,
  output logic         Busy,
  output logic         Done,
  output logic         WriteDropped
);

  localparam int DEPTH = 1 << A;

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t       state;
  logic [A-1:0] idx;
  logic [W-1:0] main_bank   [DEPTH];
  logic [W-1:0] shadow_bank [DEPTH];
  logic [W-1:0] jump_q;
  logic         busy_q;
  logic         done_q;
  logic         dropped_q;

  logic [A-1:0] addr_a;
  logic         fwd_a;
  logic         fwd_b;

  assign addr_a = SetInst ? '0 : RaddrA;
  // Forwarding only applies to writes that will actually land, so never while copying.
  assign fwd_a  = BYPASS && WriteEn && !busy_q && (Waddr == addr_a);
  assign fwd_b  = BYPASS && WriteEn && !busy_q && (Waddr == RaddrB);

  assign DataOutA     = fwd_a ? DataIn : main_bank[addr_a];
  assign DataOutB     = fwd_b ? DataIn : main_bank[RaddrB];
  assign JumpReg      = jump_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign WriteDropped = dropped_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        main_bank[i]   <= '0;
        shadow_bank[i] <= '0;
      end
      jump_q    <= '0;
      state     <= IDLE;
      idx       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= WriteEn && busy_q;
      done_q    <= 1'b0;
      if (JumpWe)
        jump_q <= DataIn;
      case (state)
        IDLE, DONE: begin
          if (WriteEn)
            main_bank[Waddr] <= DataIn;
          idx <= '0;
          if (SaveReq) begin
            state  <= SAVE;
            busy_q <= 1'b1;
          end else if (RestoreReq) begin
            state  <= RESTORE;
            busy_q <= 1'b1;
          end else begin
            state  <= IDLE;
          end
        end
        SAVE: begin
          shadow_bank[idx] <= main_bank[idx];
          idx              <= idx + 1'b1;
          if (idx == '1) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        RESTORE: begin
          main_bank[idx] <= shadow_bank[idx];
          idx            <= idx + 1'b1;
          if (idx == '1) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
